exmem_stage_reg: RTL and testbench
==================================

# exmem_stage_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake, synchronous flush, bubble gating of control fields and a saturating back-pressure counter. It sits between the execute stage (ALU, branch-target adder) and the memory stage. It replaces the transparent EX/MEM latch with a true clocked stage that can stall and be squashed. The M bundle is decoded on the output into Branch/MemWrite/MemRead, and PCSrc is produced for the fetch stage.

## Interface
- DATA_W, 32, width of BranchInst, ALUresult and Dato2
- REG_AW, 5, width of the destination register address
- CNT_W, 16, width of the stall counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  synchronous squash of all held and incoming instructions
- WB  in  2  write-back control bundle
- M  in  3  memory control bundle: bit 0 MemRead, bit 1 MemWrite, bit 2 Branch
- BranchInst  in  DATA_W  branch target address
- ZeroFlag  in  1  ALU zero
- ALUresult  in  DATA_W  ALU result
- Dato2  in  DATA_W  store data
- DirWriteReg  in  REG_AW  destination register
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM stage accepts this cycle
- O_WB  out  2  gated WB
- O_Branch, O_MemWrite, O_MemRead  out  1 each  gated, decoded from M
- O_BranchInst, O_ALUresult, O_Dato2  out  DATA_W  registered data
- O_ZeroFlag  out  1  registered zero flag
- O_DirWriteReg  out  REG_AW  registered destination
- O_PCSrc  out  1  out_valid & O_Branch & O_ZeroFlag
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready

## Operation
- A transfer occurs on each side when valid & ready are both high at a rising clk edge.
- The main entry (mreg) drives all O_* outputs. out_valid equals the mreg valid bit.
- Gating: when out_valid=0, O_WB, O_Branch, O_MemWrite, O_MemRead and O_PCSrc are 0. Data fields hold their last loaded value and are loaded only on an accepted input.
- Flush has highest priority. At the next edge every valid bit clears, and the input is discarded even if in_valid=1. in_ready is 1 during a flush cycle, so EX never deadlocks. Data registers are not cleared.
- stall_cnt increments when out_valid & !out_ready, saturates at 2^CNT_W-1, and is not cleared by flush.
- Reset (rst_n=0, asynchronous): all valid bits 0; all data/control registers 0; stall_cnt 0. All outputs are therefore 0, except in_ready, which is 1.

## Timing
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 instruction per cycle while out_ready=1.
- Without skid: in_ready = !out_valid | out_ready, which is combinational from out_ready. A simultaneous drain and fill loads the new entry in the same edge.
- Back-pressure holds every O_* output stable while out_valid & !out_ready.
- Reset deasserted mid-stream: the first edge after release behaves as an empty stage.

## Configuration
- EXMEM_SKID_EN defined: a second entry (sreg) is added.
  - in_ready = !sreg_valid, taken from a register; there is no combinational path from out_ready.
  - An input arriving while mreg is full and out_ready=0 goes to sreg.
  - When mreg drains, sreg moves to mreg on the same edge.
  - Order is strictly preserved. Flush clears both entries.
- EXMEM_SKID_EN undefined: single entry; in_ready behaves as in Timing.

## Test plan
- Reset: assert rst_n=0 mid-transfer -> all outputs 0 immediately, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, 4 back-to-back inputs with ALUresult 0x10, 0x20, 0x30, 0x40 -> same values on O_ALUresult on consecutive cycles, each 1 cycle late, out_valid continuous.
- Branch: M=3'b100, ZeroFlag=1, BranchInst=0x0000_0040 -> next cycle O_PCSrc=1, O_BranchInst=0x40. Repeat with ZeroFlag=0 -> O_PCSrc=0.
- Stall: hold out_ready=0 for 5 cycles with a valid entry -> outputs stable and stall_cnt=5. With CNT_W=2, stall_cnt saturates at 3.
- Flush: flush=1 with a full stage and in_valid=1, M=3'b011 -> next cycle out_valid=0, O_MemRead=O_MemWrite=0, and no entry appears afterwards.
- Skid (EXMEM_SKID_EN): out_ready=0, two inputs A, B accepted, then in_ready=0. Release out_ready -> A, then B delivered in order, and in_ready returns 1 one cycle after sreg empties.

Source files
------------

// File: rtl/exmem_stage_reg.sv
// -----------------------------------------------------------------------------
// exmem_stage_reg
//
// Clocked EX/MEM pipeline register with a valid/ready handshake on both
// sides. It can stall under back-pressure from MEM and can be squashed by a
// synchronous flush. The M bundle is decoded into Branch/MemWrite/MemRead on
// the way out, and PCSrc is produced here for the fetch stage.
//
// Optional feature:
//   EXMEM_SKID_EN  - when defined, a second (skid) entry is added so that
//                    in_ready comes straight from a register and has no
//                    combinational path from out_ready.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready EX-side handshake
//   flush             squash every held and incoming instruction
//   WB, M             write-back / memory control bundles
//                     (M[0] MemRead, M[1] MemWrite, M[2] Branch)
//   BranchInst, ZeroFlag, ALUresult, Dato2, DirWriteReg  execute results
//   out_valid/out_ready MEM-side handshake
//   O_*               registered entry; control fields gated by out_valid
//   O_PCSrc           out_valid & O_Branch & O_ZeroFlag
//   stall_cnt         saturating count of cycles stalled by MEM
// -----------------------------------------------------------------------------
module exmem_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [1:0]        WB,
   input  logic [2:0]        M,
   input  logic [DATA_W-1:0] BranchInst,
   input  logic              ZeroFlag,
   input  logic [DATA_W-1:0] ALUresult,
   input  logic [DATA_W-1:0] Dato2,
   input  logic [REG_AW-1:0] DirWriteReg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        O_WB,
   output logic              O_Branch,
   output logic              O_MemWrite,
   output logic              O_MemRead,
   output logic [DATA_W-1:0] O_BranchInst,
   output logic [DATA_W-1:0] O_ALUresult,
   output logic [DATA_W-1:0] O_Dato2,
   output logic              O_ZeroFlag,
   output logic [REG_AW-1:0] O_DirWriteReg,
   output logic              O_PCSrc,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int ENT_W = 2 + 3 + DATA_W + 1 + DATA_W + DATA_W + REG_AW;

   logic [ENT_W-1:0]  inEntry;
   logic [ENT_W-1:0]  mEntryQ, mEntryD;
   logic              mValidQ, mValidD;
   logic              accept;
   logic [CNT_W-1:0]  stallCntQ, stallCntD;

   logic [1:0]        mWb;
   logic [2:0]        mM;
   logic [DATA_W-1:0] mBi;
   logic              mZf;
   logic [DATA_W-1:0] mAlu;
   logic [DATA_W-1:0] mD2;
   logic [REG_AW-1:0] mDwr;

   // All incoming fields travel together as one packed entry.
   assign inEntry = {WB, M, BranchInst, ZeroFlag, ALUresult, Dato2, DirWriteReg};
   assign {mWb, mM, mBi, mZf, mAlu, mD2, mDwr} = mEntryQ;

   // A flushed cycle still reports ready but never loads anything.
   assign accept = in_valid & in_ready & ~flush;

`ifdef EXMEM_SKID_EN
   logic [ENT_W-1:0] sEntryQ, sEntryD;
   logic             sValidQ, sValidD;

   // Ready depends only on the skid register (and flush), never on out_ready.
   assign in_ready = flush | ~sValidQ;

   // Two-entry queue: the main entry refills from the skid entry first so
   // order is preserved; a new input only lands in the skid entry when the
   // main entry is full and MEM is not draining it.
   always_comb begin
      mValidD = mValidQ;
      mEntryD = mEntryQ;
      sValidD = sValidQ;
      sEntryD = sEntryQ;
      if (flush) begin
         mValidD = 1'b0;
         sValidD = 1'b0;
      end else if (!mValidQ || out_ready) begin
         if (sValidQ) begin
            mValidD = 1'b1;
            mEntryD = sEntryQ;
            sValidD = 1'b0;
         end else if (accept) begin
            mValidD = 1'b1;
            mEntryD = inEntry;
         end else begin
            mValidD = 1'b0;
         end
      end else if (accept) begin
         sValidD = 1'b1;
         sEntryD = inEntry;
      end
   end

   // Skid entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sValidQ <= 1'b0;
         sEntryQ <= '0;
      end else begin
         sValidQ <= sValidD;
         sEntryQ <= sEntryD;
      end
   end
`else
   // Single entry: a drain and a fill may happen on the same edge, so ready
   // looks straight through to out_ready.
   assign in_ready = flush | ~mValidQ | out_ready;

   // Load on an accepted input, empty on a drain with nothing behind it.
   always_comb begin
      mValidD = mValidQ;
      mEntryD = mEntryQ;
      if (flush) begin
         mValidD = 1'b0;
      end else if (accept) begin
         mValidD = 1'b1;
         mEntryD = inEntry;
      end else if (out_ready) begin
         mValidD = 1'b0;
      end
   end
`endif

   // Stall counter sticks at all-ones and ignores flush.
   always_comb begin
      stallCntD = stallCntQ;
      if (mValidQ && !out_ready && !(&stallCntQ)) begin
         stallCntD = stallCntQ + CNT_W'(1);
      end
   end

   // Main entry and counter storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mValidQ   <= 1'b0;
         mEntryQ   <= '0;
         stallCntQ <= '0;
      end else begin
         mValidQ   <= mValidD;
         mEntryQ   <= mEntryD;
         stallCntQ <= stallCntD;
      end
   end

   // Control fields are bubbled to zero when the stage is empty; data fields
   // simply show whatever was loaded last.
   assign out_valid     = mValidQ;
   assign O_WB          = mValidQ ? mWb : 2'b00;
   assign O_Branch      = mValidQ & mM[2];
   assign O_MemWrite    = mValidQ & mM[1];
   assign O_MemRead     = mValidQ & mM[0];
   assign O_PCSrc       = mValidQ & mM[2] & mZf;
   assign O_BranchInst  = mBi;
   assign O_ALUresult   = mAlu;
   assign O_Dato2       = mD2;
   assign O_ZeroFlag    = mZf;
   assign O_DirWriteReg = mDwr;
   assign stall_cnt     = stallCntQ;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_exmem_stage_reg
//
// Self-checking bench for exmem_stage_reg. A queue-based model of the stage
// tracks which instructions are held; every cycle the DUT outputs are checked
// against it. A small table of hand-computed vectors covers streaming and
// branch resolution, and hand-written sequences cover stall, flush, reset and
// (with EXMEM_SKID_EN) skid ordering. A second instance with CNT_W=2 checks
// counter saturation.
// -----------------------------------------------------------------------------
module tb_exmem_stage_reg;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] bi;
      logic        zf;
      logic [31:0] alu;
      logic [31:0] d2;
      logic [4:0]  dwr;
   } entry_t;

   typedef struct {
      logic        inValid;
      logic        outReady;
      logic [2:0]  m;
      logic        zf;
      logic [31:0] bi;
      logic [31:0] alu;
      logic        expValid;
      logic        expBranch;
      logic        expPcsrc;
      logic [31:0] expAlu;
      logic [31:0] expBi;
   } vec_t;

   logic        clk;
   logic        rstN;
   logic        inValid;
   logic        flushIn;
   logic [1:0]  wbIn;
   logic [2:0]  mIn;
   logic [31:0] biIn;
   logic        zfIn;
   logic [31:0] aluIn;
   logic [31:0] d2In;
   logic [4:0]  dwrIn;
   logic        outReady;

   logic        in_ready, out_valid, O_Branch, O_MemWrite, O_MemRead;
   logic        O_ZeroFlag, O_PCSrc;
   logic [1:0]  O_WB;
   logic [31:0] O_BranchInst, O_ALUresult, O_Dato2;
   logic [4:0]  O_DirWriteReg;
   logic [15:0] stall_cnt;

   logic        s2InReady, s2OutValid, s2Branch, s2MemWrite, s2MemRead;
   logic        s2ZeroFlag, s2PCSrc;
   logic [1:0]  s2WB;
   logic [31:0] s2BranchInst, s2ALUresult, s2Dato2;
   logic [4:0]  s2DirWriteReg;
   logic [1:0]  s2StallCnt;

   entry_t      q[$];
   entry_t      lastHead;
   int          stallCount;
   int          checkCount;
   int          passCount;
   vec_t        vecs[7];

   exmem_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(in_ready),
      .flush(flushIn), .WB(wbIn), .M(mIn), .BranchInst(biIn),
      .ZeroFlag(zfIn), .ALUresult(aluIn), .Dato2(d2In), .DirWriteReg(dwrIn),
      .out_valid(out_valid), .out_ready(outReady), .O_WB(O_WB),
      .O_Branch(O_Branch), .O_MemWrite(O_MemWrite), .O_MemRead(O_MemRead),
      .O_BranchInst(O_BranchInst), .O_ALUresult(O_ALUresult),
      .O_Dato2(O_Dato2), .O_ZeroFlag(O_ZeroFlag),
      .O_DirWriteReg(O_DirWriteReg), .O_PCSrc(O_PCSrc), .stall_cnt(stall_cnt)
   );

   exmem_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dutSmall (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(s2InReady),
      .flush(flushIn), .WB(wbIn), .M(mIn), .BranchInst(biIn),
      .ZeroFlag(zfIn), .ALUresult(aluIn), .Dato2(d2In), .DirWriteReg(dwrIn),
      .out_valid(s2OutValid), .out_ready(outReady), .O_WB(s2WB),
      .O_Branch(s2Branch), .O_MemWrite(s2MemWrite), .O_MemRead(s2MemRead),
      .O_BranchInst(s2BranchInst), .O_ALUresult(s2ALUresult),
      .O_Dato2(s2Dato2), .O_ZeroFlag(s2ZeroFlag),
      .O_DirWriteReg(s2DirWriteReg), .O_PCSrc(s2PCSrc), .stall_cnt(s2StallCnt)
   );

   // Free-running clock, first rising edge at 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the queue model.
   task automatic checkOutput();
      entry_t h;
      logic   v;
      int     sat16;
      int     sat2;
      v     = (q.size() > 0);
      h     = v ? q[0] : lastHead;
      sat16 = (stallCount > 65535) ? 65535 : stallCount;
      sat2  = (stallCount > 3) ? 3 : stallCount;
      check("out_valid",     64'(out_valid),     64'(v));
      check("O_WB",          64'(O_WB),          64'(v ? h.wb : 2'b00));
      check("O_Branch",      64'(O_Branch),      64'(v & h.m[2]));
      check("O_MemWrite",    64'(O_MemWrite),    64'(v & h.m[1]));
      check("O_MemRead",     64'(O_MemRead),     64'(v & h.m[0]));
      check("O_PCSrc",       64'(O_PCSrc),       64'(v & h.m[2] & h.zf));
      check("O_BranchInst",  64'(O_BranchInst),  64'(h.bi));
      check("O_ALUresult",   64'(O_ALUresult),   64'(h.alu));
      check("O_Dato2",       64'(O_Dato2),       64'(h.d2));
      check("O_ZeroFlag",    64'(O_ZeroFlag),    64'(h.zf));
      check("O_DirWriteReg", 64'(O_DirWriteReg), 64'(h.dwr));
      check("stall_cnt",     64'(stall_cnt),     64'(sat16));
      check("stall_cnt_w2",  64'(s2StallCnt),    64'(sat2));
   endtask

   // One clock: check in_ready mid-cycle, advance the model, check outputs.
   task automatic applyStimulus();
      logic   expReady;
      logic   push;
      logic   pop;
      entry_t cur;
      @(negedge clk);
`ifdef EXMEM_SKID_EN
      expReady = flushIn | (q.size() < 2);
`else
      expReady = flushIn | (q.size() == 0) | outReady;
`endif
      check("in_ready", 64'(in_ready), 64'(expReady));
      if (q.size() > 0 && !outReady) stallCount++;
      pop = (q.size() > 0) && outReady;
      push = inValid && expReady && !flushIn;
      cur.wb = wbIn; cur.m = mIn; cur.bi = biIn; cur.zf = zfIn;
      cur.alu = aluIn; cur.d2 = d2In; cur.dwr = dwrIn;
      @(posedge clk);
      #1;
      if (flushIn) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(cur);
      end
      if (q.size() > 0) lastHead = q[0];
      checkOutput();
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic resetDut();
      #1;
      rstN = 1'b0;
      #1;
      q.delete();
      lastHead   = '0;
      stallCount = 0;
      checkOutput();
      check("reset in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #2;
      rstN = 1'b1;
   endtask

   task automatic setIdle();
      inValid = 1'b0; flushIn = 1'b0; outReady = 1'b1;
      wbIn = 2'b00; mIn = 3'b000; biIn = '0; zfIn = 1'b0;
      aluIn = '0; d2In = '0; dwrIn = '0;
   endtask

   task automatic randomInputs(input int readyPct);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 99) < readyPct);
      flushIn  = ($urandom_range(0, 15) == 0);
      wbIn     = 2'($urandom);
      mIn      = 3'($urandom);
      biIn     = $urandom;
      zfIn     = 1'($urandom);
      aluIn    = $urandom;
      d2In     = $urandom;
      dwrIn    = 5'($urandom);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      stallCount = 0;
      lastHead   = '0;
      rstN       = 1'b0;
      setIdle();

      vecs[0] = '{1'b1, 1'b1, 3'b000, 1'b0, 32'h0,  32'h10, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 3'b000, 1'b0, 32'h0,  32'h20, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 3'b000, 1'b0, 32'h0,  32'h30, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0};
      vecs[3] = '{1'b1, 1'b1, 3'b000, 1'b0, 32'h0,  32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0};
      vecs[4] = '{1'b1, 1'b1, 3'b100, 1'b1, 32'h40, 32'h50, 1'b1, 1'b1, 1'b1, 32'h50, 32'h40};
      vecs[5] = '{1'b1, 1'b1, 3'b100, 1'b0, 32'h80, 32'h60, 1'b1, 1'b1, 1'b0, 32'h60, 32'h80};
      vecs[6] = '{1'b0, 1'b1, 3'b000, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b0, 32'h60, 32'h80};

      resetDut();

      // Streaming and branch vectors from the table.
      for (int i = 0; i < 7; i++) begin
         inValid  = vecs[i].inValid;
         outReady = vecs[i].outReady;
         mIn      = vecs[i].m;
         zfIn     = vecs[i].zf;
         biIn     = vecs[i].bi;
         aluIn    = vecs[i].alu;
         d2In     = 32'(i);
         dwrIn    = 5'(i);
         wbIn     = 2'b10;
         applyStimulus();
         check($sformatf("vec%0d out_valid", i), 64'(out_valid),    64'(vecs[i].expValid));
         check($sformatf("vec%0d branch", i),    64'(O_Branch),     64'(vecs[i].expBranch));
         check($sformatf("vec%0d pcsrc", i),     64'(O_PCSrc),      64'(vecs[i].expPcsrc));
         check($sformatf("vec%0d alu", i),       64'(O_ALUresult),  64'(vecs[i].expAlu));
         check($sformatf("vec%0d bi", i),        64'(O_BranchInst), 64'(vecs[i].expBi));
      end

      // Stall for five cycles from a fresh reset.
      resetDut();
      setIdle();
      inValid = 1'b1; aluIn = 32'hAA; mIn = 3'b010;
      applyStimulus();
      inValid = 1'b0; outReady = 1'b0; aluIn = 32'h55;
      for (int i = 0; i < 5; i++) applyStimulus();
      check("stall cnt5",    64'(stall_cnt),   64'(5));
      check("stall sat2",    64'(s2StallCnt),  64'(3));
      check("stall hold",    64'(O_ALUresult), 64'(32'hAA));
      check("stall wr held", 64'(O_MemWrite),  64'(1));
      outReady = 1'b1;
      applyStimulus();

      // Flush with a full stage and a valid incoming instruction.
      setIdle();
      inValid = 1'b1; outReady = 1'b0; mIn = 3'b011; aluIn = 32'hF1;
      applyStimulus();
      flushIn = 1'b1; aluIn = 32'hF2;
      applyStimulus();
      check("flush valid",  64'(out_valid),  64'(0));
      check("flush memrd",  64'(O_MemRead),  64'(0));
      check("flush memwr",  64'(O_MemWrite), 64'(0));
      flushIn = 1'b0; inValid = 1'b0; outReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         check("post-flush empty", 64'(out_valid), 64'(0));
      end

`ifdef EXMEM_SKID_EN
      // Two inputs under back-pressure fill both entries, then drain in order.
      resetDut();
      setIdle();
      outReady = 1'b0; inValid = 1'b1; aluIn = 32'hA1;
      applyStimulus();
      aluIn = 32'hB2;
      applyStimulus();
      inValid = 1'b0;
      #1;
      check("skid full ready", 64'(in_ready),    64'(0));
      check("skid head A",     64'(O_ALUresult), 64'(32'hA1));
      outReady = 1'b1;
      applyStimulus();
      check("skid head B",     64'(O_ALUresult), 64'(32'hB2));
      check("skid B valid",    64'(out_valid),   64'(1));
      check("skid ready back", 64'(in_ready),    64'(1));
      applyStimulus();
      check("skid drained",    64'(out_valid),   64'(0));
`endif

      // Randomized traffic with a reset asserted mid-stream.
      for (int i = 0; i < 600; i++) begin
         randomInputs((i < 300) ? 60 : 25);
         if (i == 250) begin
            inValid = 1'b1;
            resetDut();
         end
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
